// File: rtl/eeprom_pkg.sv
// Shared definitions for the emulated 24C16-class EEPROM target and its reader FSM.
package eeprom_pkg;

  localparam logic [3:0] DEV_TYPE = 4'b1010;
  localparam int         ADDR_W   = 11;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    WORD_ADDR,
    WORD_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the raw SCL/SDA pins and produces registered SCL edge and START/STOP pulses.
module i2c_line_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;
  logic r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_q;

  // Lines reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_scl_rise <= r_scl_sync & ~r_scl_prev;
      r_scl_fall <= ~r_scl_sync & r_scl_prev;
      r_start    <= r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
      r_stop     <= r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
      r_sda_q    <= r_sda_sync;
    end
  end

  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_sda      = r_sda_q;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 2 KiB EEPROM: page writes, sequential reads, emulated write cycle time.
module i2c_eeprom_target import eeprom_pkg::*; #(
  parameter int WRITE_BUSY_CYCLES = 5000,
  parameter int PAGE_BITS         = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_sda_out,
  output logic              o_sda_enable,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  output logic              o_busy,
  output logic              o_write_busy
);

  localparam int CW = (WRITE_BUSY_CYCLES > 0) ? $clog2(WRITE_BUSY_CYCLES + 1) : 1;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_line_sync u_sync (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_scl     (i_scl),
    .i_sda     (i_sda),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop),
    .o_sda     (w_sda)
  );

  state_t            r_state, w_state_n;
  logic [3:0]        r_bit_cnt, w_bit_cnt_n;
  logic [7:0]        r_shift, w_shift_n;
  logic [ADDR_W-1:0] r_ptr, w_ptr_n;
  logic              r_rw, w_rw_n;
  logic              r_sda_en, w_sda_en_n;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
  logic [7:0]        r_mem_wdata, w_mem_wdata_n;
  logic              r_mem_we, w_mem_we_n;
  logic              r_mem_re, w_mem_re_n;
  logic              r_re_d;
  logic              r_wrote, w_wrote_n;
  logic [CW-1:0]     r_busy_cnt, w_busy_cnt_n;

  logic [7:0] w_byte;
  logic       w_write_busy;

  assign w_byte       = {r_shift[6:0], w_sda};
  assign w_write_busy = (r_busy_cnt != '0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_sda_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_re_d      <= 1'b0;
      r_wrote     <= 1'b0;
      r_busy_cnt  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_shift     <= w_shift_n;
      r_ptr       <= w_ptr_n;
      r_rw        <= w_rw_n;
      r_sda_en    <= w_sda_en_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_re    <= w_mem_re_n;
      r_re_d      <= r_mem_re;
      r_wrote     <= w_wrote_n;
      r_busy_cnt  <= w_busy_cnt_n;
    end
  end

  // Bit count 8 in an ACK state means "ACK not yet driven", 9 means "9th SCL high seen".
  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_shift_n     = r_shift;
    w_ptr_n       = r_ptr;
    w_rw_n        = r_rw;
    w_sda_en_n    = r_sda_en;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_we_n    = 1'b0;
    w_mem_re_n    = 1'b0;
    w_wrote_n     = r_wrote;
    w_busy_cnt_n  = w_write_busy ? r_busy_cnt - CW'(1) : '0;

    if (r_re_d) w_shift_n = i_mem_rdata;

    if (w_stop) begin
      w_state_n  = IDLE;
      w_sda_en_n = 1'b0;
      if (r_wrote) begin
        w_busy_cnt_n = CW'(WRITE_BUSY_CYCLES);
        w_wrote_n    = 1'b0;
      end
    end else if (w_start) begin
      w_state_n   = DEV_ADDR;
      w_bit_cnt_n = '0;
      w_sda_en_n  = 1'b0;
    end else begin
      case (r_state)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_n   = w_byte;
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              if (r_state == DEV_ADDR) begin
                if (w_byte[7:4] == DEV_TYPE && !w_write_busy) begin
                  w_state_n       = DEV_ACK;
                  w_ptr_n[10:8]   = w_byte[3:1];
                  w_rw_n          = w_byte[0];
                  w_mem_re_n      = w_byte[0];
                  w_mem_addr_n    = {w_byte[3:1], r_ptr[7:0]};
                end else begin
                  w_state_n = IGNORE;
                end
              end else if (r_state == WORD_ADDR) begin
                w_state_n    = WORD_ACK;
                w_ptr_n[7:0] = w_byte;
              end else begin
                w_state_n     = WR_ACK;
                w_mem_we_n    = 1'b1;
                w_mem_addr_n  = r_ptr;
                w_mem_wdata_n = w_byte;
                w_wrote_n     = 1'b1;
                w_ptr_n[PAGE_BITS-1:0] = r_ptr[PAGE_BITS-1:0] + PAGE_BITS'(1);
              end
            end
          end
        end
        DEV_ACK, WORD_ACK, WR_ACK: begin
          if (w_scl_rise && r_bit_cnt == 4'd8) begin
            w_bit_cnt_n = 4'd9;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_en_n = 1'b1;
            end else if (r_bit_cnt == 4'd9) begin
              w_sda_en_n  = 1'b0;
              w_bit_cnt_n = '0;
              if (r_state == DEV_ACK && r_rw) begin
                w_state_n  = RD_DATA;
                w_sda_en_n = ~r_shift[7];
                w_shift_n  = {r_shift[6:0], 1'b0};
              end else if (r_state == DEV_ACK) begin
                w_state_n = WORD_ADDR;
              end else begin
                w_state_n = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) w_state_n = RD_ACK;
          end else if (w_scl_fall) begin
            w_sda_en_n = ~r_shift[7];
            w_shift_n  = {r_shift[6:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (w_scl_rise && r_bit_cnt == 4'd8) begin
            if (!w_sda) begin
              w_bit_cnt_n  = 4'd9;
              w_ptr_n      = r_ptr + 11'd1;
              w_mem_addr_n = r_ptr + 11'd1;
              w_mem_re_n   = 1'b1;
            end else begin
              w_state_n = IGNORE;
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_en_n = 1'b0;
            end else if (r_bit_cnt == 4'd9) begin
              w_state_n   = RD_DATA;
              w_bit_cnt_n = '0;
              w_sda_en_n  = ~r_shift[7];
              w_shift_n   = {r_shift[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sda_out    = 1'b0;
  assign o_sda_enable = r_sda_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_re     = r_mem_re;
  assign o_mem_we     = r_mem_we;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = (r_state != IDLE) && (r_state != IGNORE);
  assign o_write_busy = w_write_busy;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Bit-banged I2C controller with a byte memory model and a scoreboard of expected memory strobes.
module tb_i2c_eeprom_target;

  localparam int Q = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclDrv = 1'b1;
  logic        sdaLow = 1'b0;
  logic        sdaOut, sdaEnable, memRe, memWe, busy, writeBusy;
  logic [10:0] memAddr;
  logic [7:0]  memRdata = 8'h00;
  logic [7:0]  memWdata;
  logic        sdaLine;

  always #5 clock = ~clock;
  assign sdaLine = ~(sdaLow | sdaEnable);

  i2c_eeprom_target dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_scl       (sclDrv),
    .i_sda       (sdaLine),
    .o_sda_out   (sdaOut),
    .o_sda_enable(sdaEnable),
    .o_mem_addr  (memAddr),
    .o_mem_re    (memRe),
    .i_mem_rdata (memRdata),
    .o_mem_we    (memWe),
    .o_mem_wdata (memWdata),
    .o_busy      (busy),
    .o_write_busy(writeBusy)
  );

  logic [7:0] mem [0:2047];

  always @(posedge clock) begin
    if (memRe) memRdata <= mem[memAddr];
    if (memWe) mem[memAddr] <= memWdata;
  end

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  logic [18:0] expWr[$];
  logic [10:0] expRd[$];
  int          busyCycles = 0;

  // Memory strobes are popped from the scoreboard as the DUT issues them.
  always @(negedge clock) begin
    if (writeBusy) busyCycles++;
    if (memWe || memRe) checkOutput("weReExclusive", {31'd0, memWe & memRe}, 32'd0);
    if (memWe) begin
      if (expWr.size() == 0) checkOutput("unexpectedWrite", {13'd0, memAddr, memWdata}, 32'hFFFF_FFFF);
      else checkOutput("memWrite", {13'd0, memAddr, memWdata}, {13'd0, expWr.pop_front()});
    end
    if (memRe) begin
      if (expRd.size() == 0) checkOutput("unexpectedRead", {21'd0, memAddr}, 32'hFFFF_FFFF);
      else checkOutput("memReadAddr", {21'd0, memAddr}, {21'd0, expRd.pop_front()});
    end
  end

  task automatic waitQ();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2cStart();
    sdaLow = 1'b0; waitQ();
    sclDrv = 1'b1; waitQ();
    sdaLow = 1'b1; waitQ();
    sclDrv = 1'b0; waitQ();
  endtask

  task automatic i2cStop();
    sdaLow = 1'b1; waitQ();
    sclDrv = 1'b1; waitQ();
    sdaLow = 1'b0; waitQ();
  endtask

  task automatic writeBit(input logic b);
    sdaLow = ~b; waitQ();
    sclDrv = 1'b1; waitQ(); waitQ();
    sclDrv = 1'b0; waitQ();
  endtask

  task automatic readBit(output logic b);
    sdaLow = 1'b0; waitQ();
    sclDrv = 1'b1; waitQ();
    b = sdaLine; waitQ();
    sclDrv = 1'b0; waitQ();
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    readBit(ack);
  endtask

  task automatic readByte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      d[i] = b;
    end
    writeBit(nack);
  endtask

  task automatic waitWriteBusyClear();
    int n = 0;
    while (writeBusy && n < 6000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("writeBusyTimeout", {31'd0, writeBusy}, 32'd0);
  endtask

  task automatic applyStimulus();
    logic       ack;
    logic [7:0] d;
    logic [10:0] pageAddr [4];
    pageAddr[0] = 11'h33E; pageAddr[1] = 11'h33F; pageAddr[2] = 11'h330; pageAddr[3] = 11'h331;

    // Page write with tWR emulation, then address NACK while busy.
    i2cStart();
    writeByte(8'hA0, ack); checkOutput("wrDevAck", {31'd0, ack}, 0);
    writeByte(8'h35, ack); checkOutput("wrWordAck", {31'd0, ack}, 0);
    expWr.push_back({11'h035, 8'h11});
    writeByte(8'h11, ack); checkOutput("wrData0Ack", {31'd0, ack}, 0);
    expWr.push_back({11'h036, 8'h22});
    writeByte(8'h22, ack); checkOutput("wrData1Ack", {31'd0, ack}, 0);
    i2cStop();
    checkOutput("writeBusyAfterStop", {31'd0, writeBusy}, 1);
    i2cStart();
    writeByte(8'hA0, ack); checkOutput("nackWhileBusy", {31'd0, ack}, 1);
    checkOutput("busyAfterNack", {31'd0, busy}, 0);
    i2cStop();
    waitWriteBusyClear();
    checkOutput("writeBusyLength", busyCycles, 5000);
    i2cStart();
    writeByte(8'hA0, ack); checkOutput("ackAfterBusy", {31'd0, ack}, 0);
    i2cStop();

    // Page wrap inside a 16-byte page.
    i2cStart();
    writeByte(8'hA6, ack); checkOutput("pageDevAck", {31'd0, ack}, 0);
    writeByte(8'h3E, ack); checkOutput("pageWordAck", {31'd0, ack}, 0);
    for (int k = 0; k < 4; k++) begin
      expWr.push_back({pageAddr[k], 8'hD0 + 8'(k)});
      writeByte(8'hD0 + 8'(k), ack);
      checkOutput("pageDataAck", {31'd0, ack}, 0);
    end
    i2cStop();
    waitWriteBusyClear();

    // Random read through a dummy write.
    i2cStart();
    writeByte(8'hA2, ack); checkOutput("rrDevAck", {31'd0, ack}, 0);
    writeByte(8'h10, ack); checkOutput("rrWordAck", {31'd0, ack}, 0);
    i2cStart();
    expRd.push_back(11'h110);
    writeByte(8'hA3, ack); checkOutput("rrReadAck", {31'd0, ack}, 0);
    readByte(d, 1'b1); checkOutput("rrData", {24'd0, d}, 32'h5A);
    i2cStop();
    checkOutput("rrSdaReleased", {31'd0, sdaEnable}, 0);
    checkOutput("rrBusyClear", {31'd0, busy}, 0);
    checkOutput("rrNoWriteBusy", {31'd0, writeBusy}, 0);

    // Sequential read wrapping the full address space.
    i2cStart();
    writeByte(8'hAE, ack); checkOutput("swDevAck", {31'd0, ack}, 0);
    writeByte(8'hFF, ack); checkOutput("swWordAck", {31'd0, ack}, 0);
    i2cStart();
    expRd.push_back(11'h7FF);
    expRd.push_back(11'h000);
    writeByte(8'hAF, ack); checkOutput("swReadAck", {31'd0, ack}, 0);
    readByte(d, 1'b0); checkOutput("swData7FF", {24'd0, d}, 32'h81);
    readByte(d, 1'b1); checkOutput("swData000", {24'd0, d}, 32'h7E);
    i2cStop();

    // Reader-style random read at 0x123.
    i2cStart();
    writeByte(8'hA2, ack);
    writeByte(8'h23, ack);
    i2cStart();
    expRd.push_back(11'h123);
    writeByte(8'hA3, ack); checkOutput("rdrReadAck", {31'd0, ack}, 0);
    readByte(d, 1'b1); checkOutput("rdrData", {24'd0, d}, 32'hC3);
    i2cStop();

    // STOP in the middle of a data byte.
    i2cStart();
    writeByte(8'hA0, ack);
    writeByte(8'h40, ack); checkOutput("midStopWordAck", {31'd0, ack}, 0);
    for (int i = 0; i < 4; i++) writeBit(1'b0);
    i2cStop();
    checkOutput("midStopSda", {31'd0, sdaEnable}, 0);
    checkOutput("midStopNoTwr", {31'd0, writeBusy}, 0);
    checkOutput("midStopBusy", {31'd0, busy}, 0);

    // Reset while the target is driving a 0 data bit.
    i2cStart();
    writeByte(8'hA2, ack);
    writeByte(8'h24, ack);
    i2cStart();
    expRd.push_back(11'h124);
    writeByte(8'hA3, ack);
    readBit(ack);
    readBit(ack);
    checkOutput("driveLowBeforeReset", {31'd0, sdaEnable}, 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("sdaAfterReset", {31'd0, sdaEnable}, 0);
    checkOutput("busyAfterReset", {31'd0, busy}, 0);
    reset = 1'b0;
    i2cStop();

    checkOutput("writeQueueDrained", expWr.size(), 0);
    checkOutput("readQueueDrained", expRd.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h110] = 8'h5A;
    mem[11'h7FF] = 8'h81;
    mem[11'h000] = 8'h7E;
    mem[11'h123] = 8'hC3;
    mem[11'h124] = 8'h00;

    repeat (5) @(negedge clock);
    checkOutput("rstSdaEnable", {31'd0, sdaEnable}, 0);
    checkOutput("rstBusy", {31'd0, busy}, 0);
    checkOutput("rstWriteBusy", {31'd0, writeBusy}, 0);
    checkOutput("rstMemWe", {31'd0, memWe}, 0);
    checkOutput("rstMemRe", {31'd0, memRe}, 0);
    checkOutput("rstMemAddr", {21'd0, memAddr}, 0);
    checkOutput("rstMemWdata", {24'd0, memWdata}, 0);
    checkOutput("sdaOutConst", {31'd0, sdaOut}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    applyStimulus();

    repeat (20) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog got=timeout expected=completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
